// File: rtl/demux_pkg.sv
// Shared constants and helpers for the four-channel stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;  // number of output channels
    localparam int DEPTH  = 2;  // words buffered per channel
    localparam int OCC_W  = 2;  // occupancy width, holds 0..DEPTH
    localparam int ADDR_W = 2;  // channel address width
    localparam int PTR_W  = 1;  // FIFO pointer width, wraps modulo DEPTH

    // One-hot decode of a channel address.
    function automatic logic [NUM_CH-1:0] decode_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_CH-1:0] onehot;
        onehot       = '0;
        onehot[addr] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_channel_fifo.sv
// Two-entry FIFO holding the words routed to one output channel.
// The head entry is registered, so a pushed word shows up one cycle later.
module demux_channel_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [OCC_W-1:0] o_occupancy
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;

    // Guard against overflow and underflow locally; the top already gates push.
    always_comb begin
        w_do_push = i_push && (r_count != OCC_W'(DEPTH));
        w_do_pop  = i_pop && (r_count != '0);
    end

    // Storage, wrap-around pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_occupancy = r_count;

endmodule

// File: rtl/stream_demultiplexer.sv
// Routes one upstream stream to four buffered output channels selected by
// {address1, address0}. Each channel is an independent two-entry FIFO.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. in_ready depends only on registered occupancy,
// the addressed channel and reset, never on any out_ready, so a full channel
// stays not-ready for the cycle in which it is popped. Producers may change
// address or data while in_valid is high and in_ready is low; in_ready then
// follows the newly addressed channel.
module stream_demultiplexer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             address0,
    input  logic             address1,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic             out_valid3,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    input  logic             out_ready3,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [OCC_W-1:0] occupancy0,
    output logic [OCC_W-1:0] occupancy1,
    output logic [OCC_W-1:0] occupancy2,
    output logic [OCC_W-1:0] occupancy3
);

    logic [ADDR_W-1:0] w_addr;
    logic [NUM_CH-1:0] w_push_en;
    logic [NUM_CH-1:0] w_out_ready;
    logic [NUM_CH-1:0] w_out_valid;
    logic [WIDTH-1:0]  w_head [NUM_CH];
    logic [OCC_W-1:0]  w_occ  [NUM_CH];

    assign w_addr      = {address1, address0};
    assign w_out_ready = {out_ready3, out_ready2, out_ready1, out_ready0};

    // Accept decision and one-hot push enable for the addressed channel only.
    always_comb begin
        in_ready  = !reset && (w_occ[w_addr] < OCC_W'(DEPTH));
        w_push_en = '0;
        if (in_valid && in_ready) begin
            w_push_en = decode_onehot(w_addr);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_channel_fifo #(
            .WIDTH (WIDTH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .i_push      (w_push_en[k]),
            .i_pop       (w_out_ready[k] && w_out_valid[k]),
            .i_data      (in_data),
            .o_head      (w_head[k]),
            .o_occupancy (w_occ[k])
        );
        assign w_out_valid[k] = (w_occ[k] != '0);
    end

    assign out_valid0 = w_out_valid[0];
    assign out_valid1 = w_out_valid[1];
    assign out_valid2 = w_out_valid[2];
    assign out_valid3 = w_out_valid[3];
    assign out_data0  = w_head[0];
    assign out_data1  = w_head[1];
    assign out_data2  = w_head[2];
    assign out_data3  = w_head[3];
    assign occupancy0 = w_occ[0];
    assign occupancy1 = w_occ[1];
    assign occupancy2 = w_occ[2];
    assign occupancy3 = w_occ[3];

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Bench for stream_demultiplexer: directed vector table, then a random run
// against per-channel expected queues.
module tb_stream_demultiplexer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         address0, address1;
    logic         out_valid0, out_valid1, out_valid2, out_valid3;
    logic         out_ready0, out_ready1, out_ready2, out_ready3;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [1:0]   occupancy0, occupancy1, occupancy2, occupancy3;

    int errors = 0;
    int checks = 0;

    // clock / reset
    always #5 clk = ~clk;

    stream_demultiplexer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .address0   (address0),
        .address1   (address1),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_valid3 (out_valid3),
        .out_ready0 (out_ready0),
        .out_ready1 (out_ready1),
        .out_ready2 (out_ready2),
        .out_ready3 (out_ready3),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .occupancy0 (occupancy0),
        .occupancy1 (occupancy1),
        .occupancy2 (occupancy2),
        .occupancy3 (occupancy3)
    );

    logic [3:0]   ov;
    logic [7:0]   occ;
    logic [W-1:0] od [4];
    assign ov    = {out_valid3, out_valid2, out_valid1, out_valid0};
    assign occ   = {occupancy3, occupancy2, occupancy1, occupancy0};
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    // scoreboard: one expected queue per channel
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];
    logic [W-1:0] exp_q3[$];

    function automatic int q_size(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            2:       return exp_q2.size();
            default: return exp_q3.size();
        endcase
    endfunction

    function automatic logic [W-1:0] q_front(input int k);
        case (k)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            2:       return exp_q2[0];
            default: return exp_q3[0];
        endcase
    endfunction

    task automatic q_pop(input int k);
        case (k)
            0:       void'(exp_q0.pop_front());
            1:       void'(exp_q1.pop_front());
            2:       void'(exp_q2.pop_front());
            default: void'(exp_q3.pop_front());
        endcase
    endtask

    task automatic q_push(input int k, input logic [W-1:0] d);
        case (k)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            2:       exp_q2.push_back(d);
            default: exp_q3.push_back(d);
        endcase
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    // driver
    task automatic drive(input logic rst, input logic vld, input logic [1:0] addr,
                         input logic [W-1:0] data, input logic [3:0] ordy);
        reset    = rst;
        in_valid = vld;
        {address1, address0} = addr;
        in_data  = data;
        {out_ready3, out_ready2, out_ready1, out_ready0} = ordy;
    endtask

    typedef struct {
        logic         rst;
        logic         vld;
        logic [1:0]   addr;
        logic [W-1:0] data;
        logic [3:0]   ordy;
        logic         exp_irdy;   // in_ready before the edge
        logic [3:0]   exp_ov;     // after the edge
        logic [7:0]   exp_occ;    // {occ3,occ2,occ1,occ0}
        logic [31:0]  exp_dat;    // {d3,d2,d1,d0}
        logic [3:0]   dmask;      // channels whose data is compared
    } vec_t;

    vec_t vt [32];
    int   nv = 0;

    task automatic add(input logic rst, input logic vld, input logic [1:0] addr,
                       input logic [W-1:0] data, input logic [3:0] ordy, input logic irdy,
                       input logic [3:0] eov, input logic [7:0] eocc, input logic [31:0] edat,
                       input logic [3:0] mask);
        vt[nv] = '{rst, vld, addr, data, ordy, irdy, eov, eocc, edat, mask};
        nv++;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);

        // reset two cycles, then idle
        add(1, 0, 0, 8'h00, 4'h0, 0, 4'h0, 8'h00, 32'h0, 4'hF);
        add(1, 0, 0, 8'h00, 4'h0, 0, 4'h0, 8'h00, 32'h0, 4'hF);
        add(0, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h00, 32'h0, 4'hF);
        // routing to each address
        add(0, 1, 0, 8'h11, 4'h0, 1, 4'h1, 8'b00_00_00_01, 32'h00000011, 4'h1);
        add(0, 1, 1, 8'h22, 4'h0, 1, 4'h3, 8'b00_00_01_01, 32'h00002211, 4'h3);
        add(0, 1, 2, 8'h33, 4'h0, 1, 4'h7, 8'b00_01_01_01, 32'h00332211, 4'h7);
        add(0, 1, 3, 8'h44, 4'h0, 1, 4'hF, 8'b01_01_01_01, 32'h44332211, 4'hF);
        add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 32'h0, 4'h0);
        // fill channel 2, backpressure
        add(0, 1, 2, 8'hA1, 4'h0, 1, 4'h4, 8'b00_01_00_00, 32'h00A10000, 4'h4);
        add(0, 1, 2, 8'hA2, 4'h0, 1, 4'h4, 8'b00_10_00_00, 32'h00A10000, 4'h4);
        add(0, 1, 2, 8'hA3, 4'h0, 0, 4'h4, 8'b00_10_00_00, 32'h00A10000, 4'h4);
        add(0, 0, 2, 8'hA3, 4'h0, 0, 4'h4, 8'b00_10_00_00, 32'h00A10000, 4'h4);
        // address change while held; out_ready0 on empty channel ignored
        add(0, 1, 0, 8'h5A, 4'h1, 1, 4'h5, 8'b00_10_00_01, 32'h00A1005A, 4'h5);
        // full: pop A1 but no accept this cycle
        add(0, 1, 2, 8'hA3, 4'h4, 0, 4'h5, 8'b00_01_00_01, 32'h00A2005A, 4'h5);
        // occupancy 1: push A3 and pop A2 together
        add(0, 1, 2, 8'hA3, 4'h4, 1, 4'h5, 8'b00_01_00_01, 32'h00A3005A, 4'h5);
        add(0, 0, 0, 8'h00, 4'h5, 1, 4'h0, 8'h00, 32'h0, 4'h0);
        // simultaneous push/pop on channel 1
        add(0, 1, 1, 8'h05, 4'h0, 1, 4'h2, 8'b00_00_01_00, 32'h00000500, 4'h2);
        add(0, 1, 1, 8'h06, 4'h2, 1, 4'h2, 8'b00_00_01_00, 32'h00000600, 4'h2);
        add(0, 0, 0, 8'h00, 4'h2, 1, 4'h0, 8'h00, 32'h0, 4'h0);
        // fill channels 0 and 3, then reset mid-operation
        add(0, 1, 0, 8'hB0, 4'h0, 1, 4'h1, 8'b00_00_00_01, 32'h000000B0, 4'h1);
        add(0, 1, 0, 8'hB1, 4'h0, 1, 4'h1, 8'b00_00_00_10, 32'h000000B0, 4'h1);
        add(0, 1, 3, 8'hC0, 4'h0, 1, 4'h9, 8'b01_00_00_10, 32'hC00000B0, 4'h9);
        add(0, 1, 3, 8'hC1, 4'h0, 1, 4'h9, 8'b10_00_00_10, 32'hC00000B0, 4'h9);
        add(1, 1, 3, 8'hC2, 4'hF, 0, 4'h0, 8'h00, 32'h0, 4'hF);
        add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 32'h0, 4'hF);
        add(0, 1, 0, 8'hD0, 4'h0, 1, 4'h1, 8'b00_00_00_01, 32'h000000D0, 4'h1);
        add(1, 0, 0, 8'h00, 4'h0, 0, 4'h0, 8'h00, 32'h0, 4'hF);

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].vld, vt[i].addr, vt[i].data, vt[i].ordy);
            #1;
            chk("in_ready", i, 32'(in_ready), 32'(vt[i].exp_irdy));
            @(posedge clk);
            #1;
            chk("out_valid", i, 32'(ov), 32'(vt[i].exp_ov));
            chk("occupancy", i, 32'(occ), 32'(vt[i].exp_occ));
            for (int k = 0; k < 4; k++) begin
                if (vt[i].dmask[k]) begin
                    chk("out_data", i * 4 + k, 32'(od[k]), 32'(vt[i].exp_dat[k*8 +: 8]));
                end
            end
        end

        // random traffic against the scoreboard, followed by a drain
        for (int c = 0; c < 2010; c++) begin
            logic [1:0] a;
            logic [3:0] r;
            logic       erdy;
            @(negedge clk);
            a = 2'($urandom_range(0, 3));
            r = (c < 2000) ? 4'($urandom_range(0, 15)) : 4'hF;
            drive(1'b0, (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b0, a,
                  8'($urandom_range(0, 255)), r);
            #1;
            erdy = (q_size(int'(a)) < 2);
            chk("rnd_in_ready", c, 32'(in_ready), 32'(erdy));
            for (int k = 0; k < 4; k++) begin
                chk("rnd_out_valid", c * 4 + k, 32'(ov[k]), 32'(q_size(k) != 0));
                if (q_size(k) != 0) begin
                    chk("rnd_out_data", c * 4 + k, 32'(od[k]), 32'(q_front(k)));
                    if (r[k]) q_pop(k);
                end
            end
            if (in_valid && erdy) q_push(int'(a), in_data);
        end

        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("drain_queue", k, 32'(q_size(k)), 32'd0);
        end
        chk("drain_occupancy", 0, 32'(occ), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demultiplexer.md
STREAM_DEMULTIPLEXER -- requirements
Module: stream_demultiplexer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  upstream word.
REQ-007 SHALL have port address0  input  1  destination select bit 0, sampled with in_data.
REQ-008 SHALL have port address1  input  1  destination select bit 1, sampled with in_data.
REQ-009 SHALL have ports out_valid0..out_valid3  output  1 each  channel k holds a word.
REQ-010 SHALL have ports out_ready0..out_ready3  input  1 each  channel k consumer takes word.
REQ-011 SHALL have ports out_data0..out_data3  output  WIDTH each  head word of channel k.
REQ-012 SHALL have ports occupancy0..occupancy3  output  2 each  words held in channel k (0..2).

Function
REQ-013 SHALL route each accepted word to channel k = {address1, address0}; no other channel changes.
REQ-014 SHALL accept (push) when in_valid and in_ready are both high at a rising edge.
REQ-015 SHALL drive in_ready high iff the addressed channel's occupancy is below 2 and reset is low; no combinational path from any out_ready to in_ready.
REQ-016 SHALL give each channel a 2-entry FIFO; pop occurs when out_validk and out_readyk are both high at a rising edge.
REQ-017 SHALL present a word pushed at edge N on out_validk/out_datak from edge N+1 (one-cycle latency; no same-cycle bypass).
REQ-018 SHALL preserve arrival order within a channel; channels are independent and may pop concurrently.
REQ-019 SHALL drive out_validk = (occupancyk != 0) and out_datak = head entry; out_datak stays stable while out_validk high and not popped.
REQ-020 SHALL, on simultaneous push and pop to the same channel at occupancy 1, keep occupancy 1 with the new word as head next cycle.
REQ-021 SHALL, at occupancy 2, hold in_ready low for that channel even if a pop occurs that cycle; ready rises the following cycle.
REQ-022 SHALL ignore in_data/address when in_valid is low; address changes with in_valid high and in_ready low are permitted and re-evaluate in_ready.
REQ-023 SHALL wrap FIFO read/write pointers modulo 2 without loss.
REQ-024 SHALL ignore out_readyk when out_validk is low (no underflow, occupancy stays 0).

Reset
REQ-025 SHALL, while reset high at an edge, clear all occupancies to 0, pointers to 0, out_valid0..3 to 0, out_data0..3 to 0.
REQ-026 SHALL drive in_ready low during any cycle reset is high; no push occurs.
REQ-027 SHALL discard all buffered words on reset asserted mid-operation; first accept possible the cycle after reset deasserts.

Structure
REQ-028 SHALL place channel count (4), FIFO depth (2) and occupancy width (2) in a shared package demux_pkg.
REQ-029 SHALL implement each channel as one instance of sub-module demux_channel_fifo (push, pop, data, head, occupancy), instantiated four times.
REQ-030 SHALL contain an address decoder producing one-hot push enables; only the decoded channel receives push.

Verification
REQ-031 Reset: reset high 2 cycles, then low -> all out_valid 0, occupancies 0, in_ready 1 next cycle.
REQ-032 Routing: push 0x11,0x22,0x33,0x44 to addresses 0,1,2,3, all out_ready low -> out_data0..3 = 0x11,0x22,0x33,0x44, each occupancy 1.
REQ-033 Full/backpressure: push 0xA1,0xA2,0xA3 to address 2, out_ready2 low -> third held, in_ready 0, occupancy2 = 2; raise out_ready2 -> 0xA1, 0xA2, 0xA3 delivered in order.
REQ-034 Simultaneous: channel 1 holds 0x05, push 0x06 to address 1 with out_ready1 high -> occupancy1 stays 1, out_data1 = 0x06 next cycle.
REQ-035 Mid-op reset: channels 0 and 3 full, assert reset one cycle -> all occupancies 0, out_valid all 0, prior words never appear.
REQ-036 Random: 2000 cycles random valid/address/ready -> per-channel scoreboard order match, no loss, no duplication.
